shift_seq: RTL and testbench

Iterative multi-position shift unit for the 16-bit ALU. It accepts a word, a shift operation and a shift amount through a start/ready handshake, then applies one single-position shift per clock. The single-position semantics are the same as the ALU's combinational one-bit shifter. It reports the result, with a sticky overflow flag, through a one-cycle valid pulse. It sits between the ALU opcode decode and the result mux and serves multi-bit shift opcodes that the combinational one-bit path cannot complete in a single cycle.

---
 rtl/shift_seq.sv | 142 ++++++++++++++
 tb/tb_shift_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - iterative multi-position shifter (LSL/LSR/ASR/ROR), one bit per clock
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [1:0]         op_q;
  logic [AMT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               ready_q;
  logic               busy_q;
  logic               valid_q;

  logic [WIDTH-1:0]   work_d;
  logic               out_bit_d;

  // One single-position step of the captured operation and the bit it pushes out
  always_comb begin
    work_d    = work_q;
    out_bit_d = 1'b0;
    case (op_q)
      OP_LSL: begin
        work_d    = {work_q[WIDTH-2:0], 1'b0};
        out_bit_d = work_q[WIDTH-1];
      end
      OP_LSR: begin
        work_d    = {1'b0, work_q[WIDTH-1:1]};
        out_bit_d = work_q[0];
      end
      OP_ASR: begin
        work_d    = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        out_bit_d = work_q[0];
      end
      OP_ROR: begin
        // Rotation loses no bits, so it never contributes to overflow
        work_d    = {work_q[0], work_q[WIDTH-1:1]};
        out_bit_d = 1'b0;
      end
      default: begin
        work_d    = work_q;
        out_bit_d = 1'b0;
      end
    endcase
  end

  // Control FSM with registered handshake outputs; working register doubles as dout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      op_q    <= OP_LSL;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          // start wins over abort while idle
          if (start) begin
            work_q  <= din;
            op_q    <= op;
            cnt_q   <= amt;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (amt == '0) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            // Abort also beats the final step: no valid pulse, partial result left in place
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            work_q <= work_d;
            ovf_q  <= ovf_q | out_bit_d;
            cnt_q  <= cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign valid    = valid_q;
  assign dout     = work_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - table-driven directed bench for shift_seq
module tb_shift_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic [1:0]  op;
  logic [3:0]  amt;
  logic        abort;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [15:0] dout;
  logic        overflow;

  int n_cmp;
  int n_err;
  int n_excl;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] din;
    logic [3:0]  amt;
    logic [15:0] exp_dout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  shift_seq #(.WIDTH(16), .AMT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .din      (din),
    .op       (op),
    .amt      (amt),
    .abort    (abort),
    .ready    (ready),
    .busy     (busy),
    .valid    (valid),
    .dout     (dout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk({nm, " ready timeout"}, 32'(ready), 32'd1);
  endtask

  // Drives one operation, optionally poking a competing start while busy
  task automatic run_vec(input vec_t v, input bit poke);
    int vcnt;
    int vidx;
    logic [15:0] got_d;
    logic        got_o;
    int last;
    vcnt  = 0;
    vidx  = 0;
    got_d = 16'h0;
    got_o = 1'b0;
    wait_ready(v.name);
    start = 1'b1;
    op    = v.op;
    din   = v.din;
    amt   = v.amt;
    last  = int'(v.amt) + 2;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      if (ready === busy) n_excl++;
      if (valid === 1'b1) begin
        vcnt++;
        vidx  = i;
        got_d = dout;
        got_o = overflow;
      end
      if (i == 1 && poke) begin
        start = 1'b1;
        din   = 16'hFFFF;
        op    = 2'b11;
        amt   = 4'd0;
      end else begin
        start = 1'b0;
      end
    end
    chk({v.name, " valid count"}, 32'(vcnt), 32'd1);
    chk({v.name, " valid cycle"}, 32'(vidx), 32'(int'(v.amt) + 1));
    chk({v.name, " dout"}, 32'(got_d), 32'(v.exp_dout));
    chk({v.name, " overflow"}, 32'(got_o), 32'(v.exp_ovf));
    chk({v.name, " ready back"}, 32'(ready), 32'd1);
    chk({v.name, " dout hold"}, 32'(dout), 32'(v.exp_dout));
  endtask

  // Starts an LSR of 0xFFFF and asserts abort before shift edge k
  task automatic run_abort(input string nm, input logic [3:0] a, input int k);
    int vcnt;
    vcnt = 0;
    wait_ready(nm);
    start = 1'b1;
    op    = 2'b01;
    din   = 16'hFFFF;
    amt   = a;
    for (int i = 1; i <= int'(a) + 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (ready === busy) n_excl++;
      if (valid === 1'b1) vcnt++;
      if (i == k + 1) begin
        chk({nm, " ready after abort"}, 32'(ready), 32'd1);
        chk({nm, " busy after abort"}, 32'(busy), 32'd0);
      end
      abort = (i == k);
    end
    abort = 1'b0;
    chk({nm, " no valid"}, 32'(vcnt), 32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    n_excl = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    din    = 16'h0;
    op     = 2'b00;
    amt    = 4'd0;
    abort  = 1'b0;

    vecs[0] = '{"lsl_1082", 2'b00, 16'h1082, 4'd1,  16'h2104, 1'b0};
    vecs[1] = '{"lsl_a4f1", 2'b00, 16'hA4F1, 4'd1,  16'h49E2, 1'b1};
    vecs[2] = '{"lsr_8003", 2'b01, 16'h8003, 4'd1,  16'h4001, 1'b1};
    vecs[3] = '{"asr_8003", 2'b10, 16'h8003, 4'd4,  16'hF800, 1'b1};
    vecs[4] = '{"ror_0011", 2'b11, 16'h0011, 4'd4,  16'h1001, 1'b0};
    vecs[5] = '{"lsl_max",  2'b00, 16'h0003, 4'd15, 16'h8000, 1'b1};
    vecs[6] = '{"amt_zero", 2'b00, 16'h4648, 4'd0,  16'h4648, 1'b0};
    vecs[7] = '{"lsr_00ff", 2'b01, 16'h00FF, 4'd8,  16'h0000, 1'b1};
    vecs[8] = '{"asr_7fff", 2'b10, 16'h7FFF, 4'd3,  16'h0FFF, 1'b1};
    vecs[9] = '{"ror_wrap", 2'b11, 16'h8001, 4'd15, 16'h0003, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each run starts on the cycle ready returns
    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // Competing start while busy must be ignored
    run_vec('{"start_while_busy", 2'b00, 16'h1082, 4'd3, 16'h8410, 1'b0}, 1'b1);

    // Abort at the 3rd shift edge, and abort on the edge that would enter DONE
    run_abort("abort_mid", 4'd10, 3);
    run_abort("abort_last", 4'd3, 3);

    // Reset at the 5th shift edge
    wait_ready("reset_mid");
    begin
      int vcnt;
      vcnt  = 0;
      start = 1'b1;
      op    = 2'b01;
      din   = 16'hFFFF;
      amt   = 4'd10;
      for (int i = 1; i <= 9; i++) begin
        @(negedge clk);
        start = 1'b0;
        if (valid === 1'b1) vcnt++;
        if (i == 6) begin
          chk("midreset ready", 32'(ready), 32'd1);
          chk("midreset busy", 32'(busy), 32'd0);
          chk("midreset valid", 32'(valid), 32'd0);
          chk("midreset dout", 32'(dout), 32'h0);
          chk("midreset overflow", 32'(overflow), 32'd0);
          rst_n = 1'b1;
        end
        if (i == 5) rst_n = 1'b0;
      end
      chk("midreset no valid", 32'(vcnt), 32'd0);
    end
    run_vec('{"after_reset", 2'b00, 16'h0001, 4'd2, 16'h0004, 1'b0}, 1'b0);

    chk("ready/busy exclusive", 32'(n_excl), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
